// File: rtl/demux8_tdm_rx_if.sv
// Serial TDM receive bus: transmit side drives the serial beat, receiver
// returns the recovered word, slot position and status pulses.
interface demux8_tdm_rx_if;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] y;
  logic [2:0] slot;
  logic       locked;
  logic       frame_done;
  logic       sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  y, slot, locked, frame_done, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y, slot, locked, frame_done, sync_err
  );
endinterface

// File: rtl/demux8_tdm_rx.sv
// 8-slot TDM receiver: collects one serial bit per valid beat into a shadow
// register, publishes the word after slot 7 and tracks frame alignment.
module demux8_tdm_rx #(
  parameter bit SYNC_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  demux8_tdm_rx_if.slave   bus
);

  typedef enum logic [0:0] {HUNT, LOCK} state_t;

  state_t     state;
  logic [6:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HUNT;
      shadow         <= '0;
      bus.y          <= '0;
      bus.slot       <= '0;
      bus.locked     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.sync_err   <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.sync_err   <= 1'b0;
      if (bus.din_valid) begin
        unique case (state)
          HUNT: begin
            if (bus.frame_sync) begin
              shadow[0]  <= bus.din;
              bus.slot   <= 3'd1;
              bus.locked <= 1'b1;
              state      <= LOCK;
            end
          end
          LOCK: begin
            if (bus.frame_sync) begin
              // A marker anywhere but slot 0 restarts the frame on this beat.
              if (bus.slot != 3'd0) bus.sync_err <= 1'b1;
              shadow[0] <= bus.din;
              bus.slot  <= 3'd1;
            end else if (bus.slot == 3'd0) begin
              if (SYNC_CHECK) begin
                bus.sync_err <= 1'b1;
                bus.locked   <= 1'b0;
                bus.slot     <= 3'd0;
                state        <= HUNT;
              end else begin
                shadow[0] <= bus.din;
                bus.slot  <= 3'd1;
              end
            end else if (bus.slot == 3'd7) begin
              bus.y          <= {bus.din, shadow};
              bus.frame_done <= 1'b1;
              bus.slot       <= 3'd0;
            end else begin
              shadow[bus.slot] <= bus.din;
              bus.slot         <= bus.slot + 3'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux8_tdm_rx.sv
// Bench for demux8_tdm_rx: drives two receivers (marker checking on and off)
// with identical beats and compares both against a bit-collecting model.
module tb_demux8_tdm_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux8_tdm_rx_if bus0 ();
  demux8_tdm_rx_if bus1 ();

  demux8_tdm_rx #(.SYNC_CHECK(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  demux8_tdm_rx #(.SYNC_CHECK(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int vectors = 0;
  int miscompares = 0;

  // Reference: count of bits gathered in the current frame and the bits so far.
  logic       m_locked [2];
  int         m_cnt    [2];
  logic [7:0] m_part   [2];
  logic [7:0] m_word   [2];
  logic       m_done   [2];
  logic       m_err    [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_locked[i] = 1'b0; m_cnt[i] = 0; m_part[i] = 8'h00;
      m_word[i] = 8'h00; m_done[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_beat(input int i, input bit sc, input bit v, input bit fs, input bit d);
    m_done[i] = 1'b0;
    m_err[i]  = 1'b0;
    if (!v) return;
    if (!m_locked[i]) begin
      if (fs) begin
        m_locked[i] = 1'b1; m_cnt[i] = 1; m_part[i] = {7'b0, d};
      end
      return;
    end
    if (fs) begin
      if (m_cnt[i] != 0) m_err[i] = 1'b1;
      m_cnt[i] = 1; m_part[i] = {7'b0, d};
    end else if (m_cnt[i] == 0 && sc) begin
      m_err[i] = 1'b1; m_locked[i] = 1'b0;
    end else begin
      if (m_cnt[i] == 0) m_part[i] = 8'h00;
      m_part[i] = m_part[i] | (8'(d) << m_cnt[i]);
      m_cnt[i]  = m_cnt[i] + 1;
      if (m_cnt[i] == 8) begin
        m_word[i] = m_part[i]; m_done[i] = 1'b1; m_cnt[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] es [2];
    for (int i = 0; i < 2; i++) es[i] = m_locked[i] ? 3'(m_cnt[i]) : 3'd0;
    chk({tag, "/y0"},      bus0.y,                m_word[0]);
    chk({tag, "/slot0"},   {5'b0, bus0.slot},     {5'b0, es[0]});
    chk({tag, "/locked0"}, {7'b0, bus0.locked},   {7'b0, m_locked[0]});
    chk({tag, "/done0"},   {7'b0, bus0.frame_done}, {7'b0, m_done[0]});
    chk({tag, "/err0"},    {7'b0, bus0.sync_err}, {7'b0, m_err[0]});
    chk({tag, "/y1"},      bus1.y,                m_word[1]);
    chk({tag, "/slot1"},   {5'b0, bus1.slot},     {5'b0, es[1]});
    chk({tag, "/locked1"}, {7'b0, bus1.locked},   {7'b0, m_locked[1]});
    chk({tag, "/done1"},   {7'b0, bus1.frame_done}, {7'b0, m_done[1]});
    chk({tag, "/err1"},    {7'b0, bus1.sync_err}, {7'b0, m_err[1]});
  endtask

  task automatic beat(input string tag, input bit v, input bit fs, input bit d);
    @(negedge clk);
    bus0.din_valid = v; bus0.frame_sync = fs; bus0.din = d;
    bus1.din_valid = v; bus1.frame_sync = fs; bus1.din = d;
    @(posedge clk);
    model_beat(0, 1'b1, v, fs, d);
    model_beat(1, 1'b0, v, fs, d);
    #1;
    check_all(tag);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] w, input bit mark, input bit gaps);
    for (int k = 0; k < 8; k++) begin
      beat(tag, 1'b1, mark && (k == 0), w[k]);
      if (gaps) beat(tag, 1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    logic [7:0] w;
    bus0.din_valid = 1'b0; bus0.frame_sync = 1'b0; bus0.din = 1'b0;
    bus1.din_valid = 1'b0; bus1.frame_sync = 1'b0; bus1.din = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst = 1'b0;

    send_frame("first", 8'h01, 1'b1, 1'b0);
    beat("first_idle", 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      w = 8'h01 << n;
      send_frame("walk", w, 1'b1, 1'b0);
    end

    send_frame("gaps", 8'hA5, 1'b1, 1'b1);

    // Early marker on the slot-4 beat, then seven beats complete the new frame.
    w = 8'h3C;
    for (int k = 0; k < 4; k++) beat("early_pre", 1'b1, k == 0, w[k]);
    w = 8'hC9;
    beat("early_mark", 1'b1, 1'b1, w[0]);
    for (int k = 1; k < 8; k++) beat("early_post", 1'b1, 1'b0, w[k]);

    // Missing marker at slot 0: only the checking receiver drops lock.
    send_frame("sc_a", 8'h5A, 1'b1, 1'b0);
    send_frame("sc_b", 8'h96, 1'b0, 1'b0);
    send_frame("sc_c", 8'h7E, 1'b1, 1'b0);

    repeat (300) begin
      beat("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom));
    end

    // Asynchronous reset between edges while sitting at slot 5.
    send_frame("pre_rst", 8'hE7, 1'b1, 1'b0);
    w = 8'h6B;
    for (int k = 0; k < 5; k++) beat("mid_rst", 1'b1, k == 0, w[k]);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 6; k++) beat("hunt_ignore", 1'b1, 1'b0, 1'($urandom));
    send_frame("post_rst", 8'hB4, 1'b1, 1'b0);
    beat("post_idle", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
